// File: rtl/if_stage.sv
// if_stage: ARM fetch stage (pc/imem_addr out, imem_data in, IF/ID register id_pc/id_instr/id_valid, freeze/branch control, fetch/bubble counters)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);
  logic [31:0] pc;
  logic load;
  assign imem_addr = pc;
  assign load = !branch_taken && !freeze;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      id_pc <= '0;
      id_instr <= '0;
      id_valid <= 1'b0;
      fetch_count <= '0;
      bubble_count <= '0;
    end else begin
      pc <= branch_taken ? {branch_addr[31:2], 2'b00} : freeze ? pc : pc + PC_STEP;
      if (branch_taken) begin
        id_pc <= '0;
        id_instr <= '0;
        id_valid <= 1'b0;
      end else if (!freeze) begin
        id_pc <= pc + PC_STEP;
        id_instr <= imem_data;
        id_valid <= 1'b1;
      end
      fetch_count <= fetch_count + {31'd0, load};
      bubble_count <= bubble_count + {31'd0, !load};
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven directed checks plus randomized run against a behavioural fetch model
module tb_if_stage;
  logic clk = 1'b0, rst = 1'b1, freeze = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_addr = '0, imem_addr, imem_data, id_pc, id_instr, fetch_count, bubble_count;
  logic id_valid;
  int cmp = 0, err = 0;
  always #5 clk = ~clk;
  if_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_addr(imem_addr), .imem_data(imem_data), .id_pc(id_pc), .id_instr(id_instr),
    .id_valid(id_valid), .fetch_count(fetch_count), .bubble_count(bubble_count)
  );
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h0 ? 32'hE3A00014 : a == 32'h70 ? 32'hE0804103 : {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction
  assign imem_data = (freeze || branch_taken) ? 32'hDEADBEEF : rom(imem_addr);
  typedef struct {
    logic br, fr;
    logic [31:0] ba, pc, ipc, ins;
    logic v;
    logic [31:0] fc, bc;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input logic br, input logic fr, input logic [31:0] ba);
    branch_taken = br;
    freeze = fr;
    branch_addr = ba;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string n, input logic [31:0] pc, input logic [31:0] ipc, input logic [31:0] ins,
                         input logic v, input logic [31:0] fc, input logic [31:0] bc);
    chk({n, ".imem_addr"}, imem_addr, pc);
    chk({n, ".id_pc"}, id_pc, ipc);
    chk({n, ".id_instr"}, id_instr, ins);
    chk({n, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({n, ".fetch_count"}, fetch_count, fc);
    chk({n, ".bubble_count"}, bubble_count, bc);
  endtask
  logic [31:0] mp, mipc, mins, mfc, mbc;
  logic mv;
  initial begin
    tbl[0]  = '{0, 0, 0, 32'd4, 32'd4, 32'hE3A00014, 1, 1, 0};
    tbl[1]  = '{0, 0, 0, 32'd8, 32'd8, rom(32'd4), 1, 2, 0};
    tbl[2]  = '{0, 0, 0, 32'd12, 32'd12, rom(32'd8), 1, 3, 0};
    tbl[3]  = '{0, 1, 0, 32'd12, 32'd12, rom(32'd8), 1, 3, 1};
    tbl[4]  = '{0, 1, 0, 32'd12, 32'd12, rom(32'd8), 1, 3, 2};
    tbl[5]  = '{0, 0, 0, 32'd16, 32'd16, rom(32'd12), 1, 4, 2};
    tbl[6]  = '{1, 0, 32'h90, 32'h90, 0, 0, 0, 4, 3};
    tbl[7]  = '{1, 0, 32'h70, 32'h70, 0, 0, 0, 4, 4};
    tbl[8]  = '{0, 0, 0, 32'h74, 32'h74, 32'hE0804103, 1, 5, 4};
    tbl[9]  = '{1, 1, 32'h73, 32'h70, 0, 0, 0, 5, 5};
    tbl[10] = '{1, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0, 5, 6};
    tbl[11] = '{0, 0, 0, 32'h0, 32'h0, rom(32'hFFFFFFFC), 1, 6, 6};
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].br, tbl[i].fr, tbl[i].ba);
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ipc, tbl[i].ins, tbl[i].v, tbl[i].fc, tbl[i].bc);
    end
    step(0, 0, 0);
    #2;
    rst = 1'b1;
    branch_taken = 1'b1;
    freeze = 1'b1;
    branch_addr = 32'h400;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);
    chk_all("resume", 4, 4, 32'hE3A00014, 1, 1, 0);
    {mp, mipc, mins, mv, mfc, mbc} = {32'd4, 32'd4, 32'hE3A00014, 1'b1, 32'd1, 32'd0};
    for (int i = 0; i < 400; i++) begin
      automatic logic br = ($urandom % 8) == 0;
      automatic logic fr = ($urandom % 4) == 0;
      automatic logic [31:0] ba = ($urandom % 4 == 0) ? 32'hFFFFFFF0 | ($urandom % 16) : $urandom;
      step(br, fr, ba);
      if (br) begin
        mp = ba & ~32'd3;
        {mipc, mins, mv} = '0;
        mbc++;
      end else if (fr) mbc++;
      else begin
        mins = rom(mp);
        mipc = mp + 4;
        mv = 1'b1;
        mp = mp + 4;
        mfc++;
      end
      chk_all($sformatf("rand%0d", i), mp, mipc, mins, mv, mfc, mbc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the ARM pipeline. It owns the program counter, drives the address of the combinational instruction memory, and registers the returned instruction with its PC+4 into the IF/ID pipeline register for the decode stage. It handles hazard freeze, branch redirection and flush from later stages. It also keeps fetch and bubble counters for lab bring-up.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset
- PC_STEP, 32'd4, sequential PC increment in bytes
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- freeze  input  1  hazard stall from the hazard unit; holds PC and IF/ID
- branch_taken  input  1  branch resolved taken; redirects PC and flushes IF/ID
- branch_addr  input  32  branch target byte address
- imem_addr  output  32  address to instruction memory; always equals pc
- imem_data  input  32  instruction word returned combinationally by instruction memory
- id_pc  output  32  registered PC+4 of the instruction in IF/ID
- id_instr  output  32  registered instruction word
- id_valid  output  1  IF/ID holds a real fetched instruction; 0 means bubble
- fetch_count  output  32  number of instructions loaded into IF/ID
- bubble_count  output  32  number of cycles IF/ID did not load a new instruction

## Operation
- Reset (async, immediate): pc=RESET_PC, id_pc=0, id_instr=0, id_valid=0, fetch_count=0, bubble_count=0. imem_addr therefore equals RESET_PC during reset.
- PC update, per rising edge, in priority order:
  - branch_taken: pc <= {branch_addr[31:2],2'b00}.
  - else if freeze: pc holds.
  - else: pc <= pc+PC_STEP, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- IF/ID update, per rising edge, in priority order:
  - branch_taken: id_instr<=0, id_pc<=0, id_valid<=0. Word 0 is the pipeline NOP.
  - else if freeze: all IF/ID fields hold.
  - else: id_instr<=imem_data, id_pc<=pc+PC_STEP, id_valid<=1.
- Counters: each counter increments by at most 1 per cycle and wraps modulo 2^32.
  - fetch_count increments on a cycle that takes the IF/ID load branch.
  - bubble_count increments on a cycle that takes the flush or freeze branch.
  - Exactly one counter increments per non-reset cycle.
- Simultaneous branch_taken and freeze: branch wins. PC is redirected, IF/ID is flushed, and bubble_count increments once.
- imem_data is sampled only on load cycles. X on imem_data during freeze or flush must not propagate.

## Timing
- imem_addr is combinational from the pc register: zero-cycle latency, no input-to-output combinational path.
- Fetch latency is 1 cycle. The instruction at address A appears on id_instr on the edge after imem_addr=A, provided that edge is a load.
- Branch: if branch_taken is high at edge N, then after edge N pc=target and id_valid=0. The target instruction is in IF/ID after edge N+1 unless that edge is frozen.
- Freeze for k cycles: pc and IF/ID are stable for k edges, and bubble_count rises by k.
- Reset deassertion: the first load occurs on the first rising edge with rst low. That load fetches RESET_PC, giving id_pc=RESET_PC+4.
- Reset asserted mid-run clears all state without waiting for clk. Pending branch or freeze inputs are ignored while rst is high.

## Test plan
- Reset, then 3 free edges with the lab program ROM -> id_pc sequence 4, 8, 12.
  - After edge 1: id_instr=0xE3A00014 (MOV R0,#20).
  - id_valid=1 from the first edge; fetch_count=3, bubble_count=0.
- Run to pc=12, then freeze for 2 edges -> imem_addr stays 12, id_pc stays 12, id_instr unchanged, bubble_count=2. Release -> next id_pc=16.
- branch_taken with branch_addr=0x70 at pc=0x90:
  - After that edge: pc=0x70, id_valid=0, id_instr=0.
  - After the next edge: id_pc=0x74, id_instr=word at 0x70 (ADD R4,R0,R3,LSL #2).
- branch_taken and freeze high together with branch_addr=0x73 -> pc=0x70 (low bits cleared), IF/ID flushed, bubble_count +1, fetch_count unchanged.
- Force pc to 0xFFFFFFFC via branch, then one free edge -> pc=0x00000000, id_pc=0x00000000.
- Assert rst asynchronously between edges mid-run -> all outputs zero and imem_addr=RESET_PC before the next clk edge. Counters resume from 0 after release.
